// File: rtl/ctrl_unit_seq.sv
// ctrl_unit_seq
// Registered ID-stage control unit with a block-transfer micro-op sequencer.
// It decodes a 32-bit ARM instruction into the ID/EX control bundle and
// registers it. Stall and flush requests from the pipeline are honoured.
// LDM/STM is expanded into one single-register load/store per set bit of
// the register list. Fetch is held while that sequence runs.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   instr, instr_valid  instruction from IF/ID and its valid flag
//   stall_in            hold all state and outputs
//   flush               squash to NOP and abort any block sequence
//   ex_*                registered control bundle towards EX
//   uop_valid/reg/offset/last  block-transfer micro-op descriptor
//   if_stall            hold PC and IF/ID while a block is being expanded
module ctrl_unit_seq #(
    parameter int LIST_W    = 16,
    parameter int ADDR_STEP = 4,
    parameter int OFFS_W    = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    input  logic              stall_in,
    input  logic              flush,
    output logic              ex_shift_imm,
    output logic [3:0]        ex_alu_op,
    output logic              ex_m_size,
    output logic              ex_m_enable,
    output logic              ex_m_rw,
    output logic              ex_load_inst,
    output logic              ex_s,
    output logic              ex_rf_enable,
    output logic              ex_b_instr,
    output logic              uop_valid,
    output logic [3:0]        uop_reg,
    output logic [OFFS_W-1:0] uop_offset,
    output logic              uop_last,
    output logic              if_stall
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BLOCK = 1'b1
    } state_t;

    typedef struct packed {
        logic       shift_imm;
        logic [3:0] alu_op;
        logic       m_size;
        logic       m_enable;
        logic       m_rw;
        logic       load_inst;
        logic       s;
        logic       rf_enable;
        logic       b_instr;
    } ctrl_t;

    localparam logic [OFFS_W-1:0] STEP = OFFS_W'(ADDR_STEP);

    state_t              state_q, state_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic                uop_valid_q, uop_valid_d;
    logic [3:0]          uop_reg_q, uop_reg_d;
    logic [OFFS_W-1:0]   uop_offset_q, uop_offset_d;
    logic                uop_last_q, uop_last_d;
    logic [LIST_W-1:0]   rem_q, rem_d;
    logic                blk_l_q, blk_l_d;
    logic                blk_u_q, blk_u_d;
    logic [OFFS_W-1:0]   cnt_q, cnt_d;

    logic [LIST_W-1:0]   list_in;
    logic                unused_instr;

    assign list_in      = instr[LIST_W-1:0];
    assign unused_instr = ^instr;

    // Index of the lowest set bit; the descending loop lets the lowest hit win.
    function automatic logic [3:0] low_idx(input logic [LIST_W-1:0] l);
        logic [3:0] idx;
        idx = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (l[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // A micro-op looks like a word-sized LS-imm load/store.
    function automatic ctrl_t ls_uop(input logic load, input logic up);
        ctrl_t c;
        c           = '0;
        c.shift_imm = 1'b1;
        c.alu_op    = up ? 4'b0100 : 4'b0010;
        c.m_enable  = 1'b1;
        c.m_rw      = ~load;
        c.load_inst = load;
        c.rf_enable = load;
        return c;
    endfunction

    // Next-state and next-output logic.
    // Priority is flush > stall > normal. The default is a NOP output with
    // the sequencer context held.
    always_comb begin
        state_d      = state_q;
        ctrl_d       = '0;
        uop_valid_d  = 1'b0;
        uop_reg_d    = '0;
        uop_offset_d = '0;
        uop_last_d   = 1'b0;
        rem_d        = rem_q;
        blk_l_d      = blk_l_q;
        blk_u_d      = blk_u_q;
        cnt_d        = cnt_q;

        if (flush) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (stall_in) begin
            ctrl_d       = ctrl_q;
            uop_valid_d  = uop_valid_q;
            uop_reg_d    = uop_reg_q;
            uop_offset_d = uop_offset_q;
            uop_last_d   = uop_last_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_valid && (instr != 32'd0)) begin
                        case (instr[27:25])
                            3'b000: begin
                                ctrl_d.s         = instr[20];
                                ctrl_d.alu_op    = instr[24:21];
                                ctrl_d.rf_enable = 1'b1;
                                ctrl_d.shift_imm = (instr[11:7] != 5'd0);
                            end
                            3'b001: begin
                                ctrl_d.s         = instr[20];
                                ctrl_d.alu_op    = instr[24:21];
                                ctrl_d.rf_enable = 1'b1;
                                ctrl_d.shift_imm = 1'b1;
                            end
                            3'b010, 3'b011: begin
                                ctrl_d.shift_imm = ~instr[25];
                                ctrl_d.load_inst = instr[20];
                                ctrl_d.m_size    = instr[22];
                                ctrl_d.m_enable  = 1'b1;
                                ctrl_d.m_rw      = ~instr[20];
                                ctrl_d.rf_enable = instr[20];
                                ctrl_d.alu_op    = instr[23] ? 4'b0100 : 4'b0010;
                            end
                            3'b101: begin
                                ctrl_d.b_instr   = 1'b1;
                                ctrl_d.rf_enable = instr[24];
                                ctrl_d.alu_op    = instr[24] ? 4'b0100 : 4'b0010;
                            end
                            3'b100: begin
                                if (list_in != '0) begin
                                    ctrl_d       = ls_uop(instr[20], instr[23]);
                                    uop_valid_d  = 1'b1;
                                    uop_reg_d    = low_idx(list_in);
                                    uop_offset_d = '0;
                                    // x & (x-1) clears the lowest set bit
                                    rem_d        = list_in & (list_in - 1'b1);
                                    blk_l_d      = instr[20];
                                    blk_u_d      = instr[23];
                                    cnt_d        = STEP;
                                    if (rem_d != '0) begin
                                        state_d = BLOCK;
                                    end else begin
                                        uop_last_d = 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                BLOCK: begin
                    ctrl_d       = ls_uop(blk_l_q, blk_u_q);
                    uop_valid_d  = 1'b1;
                    uop_reg_d    = low_idx(rem_q);
                    uop_offset_d = cnt_q;
                    cnt_d        = cnt_q + STEP;
                    rem_d        = rem_q & (rem_q - 1'b1);
                    if (rem_d == '0) begin
                        uop_last_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ctrl_q       <= '0;
            uop_valid_q  <= 1'b0;
            uop_reg_q    <= '0;
            uop_offset_q <= '0;
            uop_last_q   <= 1'b0;
            rem_q        <= '0;
            blk_l_q      <= 1'b0;
            blk_u_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            uop_valid_q  <= uop_valid_d;
            uop_reg_q    <= uop_reg_d;
            uop_offset_q <= uop_offset_d;
            uop_last_q   <= uop_last_d;
            rem_q        <= rem_d;
            blk_l_q      <= blk_l_d;
            blk_u_q      <= blk_u_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ex_shift_imm = ctrl_q.shift_imm;
    assign ex_alu_op    = ctrl_q.alu_op;
    assign ex_m_size    = ctrl_q.m_size;
    assign ex_m_enable  = ctrl_q.m_enable;
    assign ex_m_rw      = ctrl_q.m_rw;
    assign ex_load_inst = ctrl_q.load_inst;
    assign ex_s         = ctrl_q.s;
    assign ex_rf_enable = ctrl_q.rf_enable;
    assign ex_b_instr   = ctrl_q.b_instr;
    assign uop_valid    = uop_valid_q;
    assign uop_reg      = uop_reg_q;
    assign uop_offset   = uop_offset_q;
    assign uop_last     = uop_last_q;
    assign if_stall     = (state_q == BLOCK);

endmodule

// File: tb/tb_ctrl_unit_seq.sv
// tb_ctrl_unit_seq
// Directed testbench for ctrl_unit_seq.
// Each vector is driven for one clock. The outputs are sampled 1 ns after
// the rising edge and compared against hand-decoded expected values.
module tb_ctrl_unit_seq;

    logic        clk;
    logic        reset_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall_in;
    logic        flush;
    logic        ex_shift_imm;
    logic [3:0]  ex_alu_op;
    logic        ex_m_size;
    logic        ex_m_enable;
    logic        ex_m_rw;
    logic        ex_load_inst;
    logic        ex_s;
    logic        ex_rf_enable;
    logic        ex_b_instr;
    logic        uop_valid;
    logic [3:0]  uop_reg;
    logic [5:0]  uop_offset;
    logic        uop_last;
    logic        if_stall;

    int checks   = 0;
    int failures = 0;

    ctrl_unit_seq #(.LIST_W(16), .ADDR_STEP(4), .OFFS_W(6)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .stall_in     (stall_in),
        .flush        (flush),
        .ex_shift_imm (ex_shift_imm),
        .ex_alu_op    (ex_alu_op),
        .ex_m_size    (ex_m_size),
        .ex_m_enable  (ex_m_enable),
        .ex_m_rw      (ex_m_rw),
        .ex_load_inst (ex_load_inst),
        .ex_s         (ex_s),
        .ex_rf_enable (ex_rf_enable),
        .ex_b_instr   (ex_b_instr),
        .uop_valid    (uop_valid),
        .uop_reg      (uop_reg),
        .uop_offset   (uop_offset),
        .uop_last     (uop_last),
        .if_stall     (if_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The expected control word is packed as
    // {shift_imm, alu_op, m_size, m_enable, m_rw, load_inst, s, rf_enable, b_instr}.
    function automatic logic [11:0] mkCtrl(input logic sh, input logic [3:0] alu,
                                           input logic sz, input logic en, input logic rw,
                                           input logic ld, input logic s, input logic rf,
                                           input logic b);
        return {sh, alu, sz, en, rw, ld, s, rf, b};
    endfunction

    // The expected micro-op is packed as {valid, reg, offset, last}.
    function automatic logic [11:0] mkUop(input logic v, input logic [3:0] r,
                                          input logic [5:0] off, input logic last);
        return {v, r, off, last};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [11:0] ectrl,
                            input logic [11:0] euop, input logic estall);
        checkOutput({tag, ".ctrl"},
                    32'({ex_shift_imm, ex_alu_op, ex_m_size, ex_m_enable, ex_m_rw,
                         ex_load_inst, ex_s, ex_rf_enable, ex_b_instr}), 32'(ectrl));
        checkOutput({tag, ".uop"}, 32'({uop_valid, uop_reg, uop_offset, uop_last}), 32'(euop));
        checkOutput({tag, ".if_stall"}, 32'(if_stall), 32'(estall));
    endtask

    task automatic applyStimulus(input logic [31:0] i, input logic v,
                                 input logic st, input logic fl);
        instr       = i;
        instr_valid = v;
        stall_in    = st;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_DPSI  = 32'hE0912003;
    localparam logic [31:0] I_ADDSH = 32'hE0812103;
    localparam logic [31:0] I_DPI   = 32'hE2811001;
    localparam logic [31:0] I_LDRB  = 32'hE5D21004;
    localparam logic [31:0] I_STR   = 32'hE5021004;
    localparam logic [31:0] I_BL    = 32'hEB000010;
    localparam logic [31:0] I_LDM   = 32'hE89000A1;
    localparam logic [31:0] I_LDM2  = 32'hE8908001;
    localparam logic [31:0] I_STM1  = 32'hE9000008;
    localparam logic [31:0] I_LDM0  = 32'hE8900000;

    logic [11:0] cNop, cDpsi, cAddSh, cDpi, cLdrb, cStr, cBl, cLdm, cStm;

    initial begin
        cNop   = 12'h000;
        cDpsi  = mkCtrl(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cAddSh = mkCtrl(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cDpi   = mkCtrl(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cLdrb  = mkCtrl(1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cStr   = mkCtrl(1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cBl    = mkCtrl(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cLdm   = mkCtrl(1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cStm   = mkCtrl(1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        reset_n     = 1'b0;
        instr       = 32'd0;
        instr_valid = 1'b0;
        stall_in    = 1'b0;
        flush       = 1'b0;
        #3;
        checkAll("reset", cNop, 12'h000, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Ordinary decode
        applyStimulus(I_DPSI, 1'b1, 1'b0, 1'b0);
        checkAll("dpsi", cDpsi, 12'h000, 1'b0);
        applyStimulus(I_ADDSH, 1'b1, 1'b0, 1'b0);
        checkAll("add_shimm", cAddSh, 12'h000, 1'b0);
        applyStimulus(I_DPI, 1'b1, 1'b0, 1'b0);
        checkAll("dpi", cDpi, 12'h000, 1'b0);
        applyStimulus(I_LDRB, 1'b1, 1'b0, 1'b0);
        checkAll("ldrb", cLdrb, 12'h000, 1'b0);
        applyStimulus(I_STR, 1'b1, 1'b0, 1'b0);
        checkAll("str_u0", cStr, 12'h000, 1'b0);
        applyStimulus(I_BL, 1'b0, 1'b0, 1'b0);
        checkAll("bubble", cNop, 12'h000, 1'b0);
        applyStimulus(32'd0, 1'b1, 1'b0, 1'b0);
        checkAll("zero_instr", cNop, 12'h000, 1'b0);
        applyStimulus(32'hEC000000, 1'b1, 1'b0, 1'b0);
        checkAll("type110", cNop, 12'h000, 1'b0);
        applyStimulus(32'hEF000000, 1'b1, 1'b0, 1'b0);
        checkAll("type111", cNop, 12'h000, 1'b0);

        // LDMIA {r0,r5,r7}; the instr seen in BLOCK must be ignored
        applyStimulus(I_LDM, 1'b1, 1'b0, 1'b0);
        checkAll("ldm.u0", cLdm, mkUop(1'b1, 4'd0, 6'd0, 1'b0), 1'b1);
        applyStimulus(I_DPSI, 1'b1, 1'b0, 1'b0);
        checkAll("ldm.u1", cLdm, mkUop(1'b1, 4'd5, 6'd4, 1'b0), 1'b1);
        applyStimulus(I_DPSI, 1'b1, 1'b0, 1'b0);
        checkAll("ldm.u2", cLdm, mkUop(1'b1, 4'd7, 6'd8, 1'b1), 1'b0);
        applyStimulus(32'd0, 1'b0, 1'b0, 1'b0);
        checkAll("ldm.after", cNop, 12'h000, 1'b0);

        // Stall during the sequence
        applyStimulus(I_LDM, 1'b1, 1'b0, 1'b0);
        checkAll("stl.u0", cLdm, mkUop(1'b1, 4'd0, 6'd0, 1'b0), 1'b1);
        applyStimulus(I_DPSI, 1'b1, 1'b1, 1'b0);
        checkAll("stl.hold", cLdm, mkUop(1'b1, 4'd0, 6'd0, 1'b0), 1'b1);
        applyStimulus(I_DPSI, 1'b1, 1'b0, 1'b0);
        checkAll("stl.u1", cLdm, mkUop(1'b1, 4'd5, 6'd4, 1'b0), 1'b1);
        applyStimulus(I_DPSI, 1'b1, 1'b0, 1'b0);
        checkAll("stl.u2", cLdm, mkUop(1'b1, 4'd7, 6'd8, 1'b1), 1'b0);

        // Stall on an ordinary instruction holds the previous output
        applyStimulus(I_BL, 1'b1, 1'b1, 1'b0);
        checkAll("stl.plain", cLdm, mkUop(1'b1, 4'd7, 6'd8, 1'b1), 1'b0);

        // Flush during BLOCK
        applyStimulus(I_LDM, 1'b1, 1'b0, 1'b0);
        checkAll("fl.u0", cLdm, mkUop(1'b1, 4'd0, 6'd0, 1'b0), 1'b1);
        applyStimulus(I_DPSI, 1'b1, 1'b0, 1'b1);
        checkAll("fl.nop", cNop, 12'h000, 1'b0);
        applyStimulus(I_BL, 1'b1, 1'b0, 1'b0);
        checkAll("fl.bl", cBl, 12'h000, 1'b0);

        // Flush and stall together: flush wins
        applyStimulus(I_LDM, 1'b1, 1'b0, 1'b0);
        checkAll("fs.u0", cLdm, mkUop(1'b1, 4'd0, 6'd0, 1'b0), 1'b1);
        applyStimulus(I_DPSI, 1'b1, 1'b1, 1'b1);
        checkAll("fs.nop", cNop, 12'h000, 1'b0);
        applyStimulus(I_BL, 1'b1, 1'b0, 1'b0);
        checkAll("fs.bl", cBl, 12'h000, 1'b0);

        // Single-register STMDB {r3}: one cycle, last immediately, no stall
        applyStimulus(I_STM1, 1'b1, 1'b0, 1'b0);
        checkAll("stm1", cStm, mkUop(1'b1, 4'd3, 6'd0, 1'b1), 1'b0);
        // Empty register list: NOP
        applyStimulus(I_LDM0, 1'b1, 1'b0, 1'b0);
        checkAll("ldm_empty", cNop, 12'h000, 1'b0);
        // LDMIA {r0,r15}: top bit of the list
        applyStimulus(I_LDM2, 1'b1, 1'b0, 1'b0);
        checkAll("ldm15.u0", cLdm, mkUop(1'b1, 4'd0, 6'd0, 1'b0), 1'b1);
        applyStimulus(32'd0, 1'b0, 1'b0, 1'b0);
        checkAll("ldm15.u1", cLdm, mkUop(1'b1, 4'd15, 6'd4, 1'b1), 1'b0);

        // Asynchronous reset in the middle of a block
        applyStimulus(I_LDM, 1'b1, 1'b0, 1'b0);
        checkAll("rst.u0", cLdm, mkUop(1'b1, 4'd0, 6'd0, 1'b0), 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checkAll("rst.async", cNop, 12'h000, 1'b0);
        @(posedge clk);
        #1;
        checkAll("rst.held", cNop, 12'h000, 1'b0);
        reset_n = 1'b1;
        applyStimulus(32'd0, 1'b0, 1'b0, 1'b0);
        checkAll("rst.idle", cNop, 12'h000, 1'b0);
        applyStimulus(I_DPSI, 1'b1, 1'b0, 1'b0);
        checkAll("rst.dpsi", cDpsi, 12'h000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
